// File: rtl/peak_scan_sequencer.sv
// Peak scan sequencer: walks one signed comparator across NUM_PAIRS
// cross-correlation vectors, one lag per cycle, and reports the index of the
// largest value above MIN_XCORR_VAL for each microphone pair.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and data stable
// until that edge; ready never depends combinationally on valid.
module peak_scan_sequencer #(
    parameter int NUM_BITS_XCORRS = 34,
    parameter int MAX_LAGS        = 17,
    parameter int BITS_PER_XCORR  = 6,
    parameter int NUM_PAIRS       = 3,
    parameter int MIN_XCORR_VAL   = 1000
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [NUM_PAIRS*(2*MAX_LAGS+1)*NUM_BITS_XCORRS-1:0]   in_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [NUM_PAIRS*BITS_PER_XCORR-1:0]                   out_lags,
    output logic [NUM_PAIRS-1:0]                                  out_found,
    output logic                                                  busy
);
    localparam int L  = 2*MAX_LAGS + 1;
    localparam int W  = NUM_BITS_XCORRS;
    localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

    // All-ones lag index lies outside 0..L-1 and marks "no qualifying lag".
    localparam logic [BITS_PER_XCORR-1:0] SENTINEL  = '1;
    localparam logic [BITS_PER_XCORR-1:0] LAST_LAG  = BITS_PER_XCORR'(L - 1);
    localparam logic [PW-1:0]             LAST_PAIR = PW'(NUM_PAIRS - 1);
    localparam logic signed [W-1:0]       THRESH    = W'(MIN_XCORR_VAL);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                                       state;
    logic signed [W-1:0]                          frame_buf [NUM_PAIRS][L];
    logic [PW-1:0]                                pair_cnt;
    logic [BITS_PER_XCORR-1:0]                    lag_cnt;
    logic signed [W-1:0]                          run_max;
    logic [BITS_PER_XCORR-1:0]                    run_idx;
    logic                                         run_found;
    logic [NUM_PAIRS-1:0][BITS_PER_XCORR-1:0]     res_lags;
    logic [NUM_PAIRS-1:0]                         res_found;

    logic signed [W-1:0]                          cur_val;
    logic                                         hit;
    logic [BITS_PER_XCORR-1:0]                    next_idx;
    logic                                         next_found;

    assign cur_val   = frame_buf[pair_cnt][lag_cnt];
    assign out_lags  = res_lags;
    assign out_found = res_found;

    // Strict greater-than keeps the earliest lag on ties; run_max starts at the
    // threshold so values equal to it never qualify.
    always_comb begin
        hit        = (cur_val > run_max);
        next_idx   = hit ? lag_cnt : run_idx;
        next_found = hit | run_found;
    end

    // Frame buffer capture on an accepted input transfer; data needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            for (int p = 0; p < NUM_PAIRS; p++) begin
                for (int k = 0; k < L; k++) begin
                    frame_buf[p][k] <= in_data[(p*L + k)*W +: W];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and per-pair result slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            pair_cnt  <= '0;
            lag_cnt   <= '0;
            run_max   <= THRESH;
            run_idx   <= SENTINEL;
            run_found <= 1'b0;
            res_lags  <= {NUM_PAIRS{SENTINEL}};
            res_found <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pair_cnt  <= '0;
                        lag_cnt   <= '0;
                        run_max   <= THRESH;
                        run_idx   <= SENTINEL;
                        run_found <= 1'b0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (lag_cnt == LAST_LAG) begin
                        // Last lag of this pair: commit including this cycle's compare.
                        res_lags[pair_cnt]  <= next_idx;
                        res_found[pair_cnt] <= next_found;
                        run_max   <= THRESH;
                        run_idx   <= SENTINEL;
                        run_found <= 1'b0;
                        lag_cnt   <= '0;
                        if (pair_cnt == LAST_PAIR) begin
                            pair_cnt  <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            pair_cnt <= pair_cnt + 1'b1;
                        end
                    end else begin
                        if (hit) begin
                            run_max <= cur_val;
                        end
                        run_idx   <= next_idx;
                        run_found <= next_found;
                        lag_cnt   <= lag_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_peak_scan_sequencer.sv
// Directed bench for peak_scan_sequencer: hand-built frames with known peaks,
// expected results queued at accept time and checked when results are taken.
module tb_peak_scan_sequencer;
    localparam int W    = 34;
    localparam int ML   = 17;
    localparam int L    = 2*ML + 1;
    localparam int B    = 6;
    localparam int NP   = 3;
    localparam int MINV = 1000;
    localparam int LAT  = NP*L + 1;
    localparam int FW   = NP*L*W;
    localparam int EW   = NP*B + NP;

    localparam logic [W-1:0] BIG = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG = {1'b1, {(W-1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [NP*B-1:0] out_lags;
    logic [NP-1:0] out_found;
    logic          busy;

    peak_scan_sequencer #(
        .NUM_BITS_XCORRS(W), .MAX_LAGS(ML), .BITS_PER_XCORR(B),
        .NUM_PAIRS(NP), .MIN_XCORR_VAL(MINV)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_lags(out_lags), .out_found(out_found), .busy(busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FW-1:0]   fr;
    logic [NP*B-1:0] e_lags;
    logic [NP-1:0]   e_found;
    logic [EW-1:0]   exp_q[$];
    int              acc_q[$];
    int              checks = 0;
    int              failures = 0;
    bit              prev_ov = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_val(input int p, input int k, input logic [W-1:0] v);
        fr[(p*L + k)*W +: W] = v;
    endtask

    task automatic set_pair(input int p, input logic [W-1:0] v);
        for (int k = 0; k < L; k++) set_val(p, k, v);
    endtask

    // Directed frames with hand-derived expectations (pair 2 is the MSB field).
    task automatic build(input int id);
        fr = '0;
        case (id)
            1: begin
                set_val(0, 5, 2000);
                set_val(1, 34, 3000);
                set_val(2, 0, 2000); set_val(2, 10, 1500); set_val(2, 34, 3000);
                e_lags = {6'd34, 6'd34, 6'd5}; e_found = 3'b111;
            end
            2: begin
                set_val(0, 3, 5000); set_val(0, 20, 5000);
                set_val(1, 7, 1000);
                set_pair(2, -7); set_val(2, 0, 1001);
                e_lags = {6'd0, 6'd63, 6'd3}; e_found = 3'b101;
            end
            3: begin
                set_pair(0, NEG); set_val(0, 17, BIG);
                set_pair(1, NEG);
                set_pair(2, 999); set_val(2, 34, 1001);
                e_lags = {6'd34, 6'd63, 6'd17}; e_found = 3'b101;
            end
            default: begin
                for (int k = 0; k < L; k++) begin
                    set_val(0, k, k*100);
                    set_val(1, k, 5000 - k*100);
                end
                set_pair(2, 2000);
                e_lags = {6'd0, 6'd0, 6'd34}; e_found = 3'b111;
            end
        endcase
    endtask

    // Driver: present a frame, wait for acceptance, queue its expected result.
    task automatic send_frame(input int id, input bit hold);
        bit got;
        got = 1'b0;
        build(id);
        @(posedge clk); #1;
        in_data  = fr;
        in_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_timeout", got, 1);
        if (got) exp_q.push_back({e_lags, e_found});
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 600; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor/scoreboard: latency on out_valid rise, results on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    check("latency", cyc - acc_q.pop_front(), LAT);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result: got result expected none (t=%0t)", $time);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("out_lags", out_lags, e[EW-1:NP]);
                    check("out_found", out_found, e[NP-1:0]);
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_lags", out_lags, 18'h3FFFF);
        check("rst_out_found", out_found, 0);

        // Basic peaks, ties/threshold, extremes.
        send_frame(1, 0);
        wait_drain();
        send_frame(2, 0);
        send_frame(3, 0);
        wait_drain();

        // Backpressure in DONE with ignored input pulses.
        out_ready = 1'b0;
        send_frame(4, 0);
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", seen, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            check("bp_lags_hold", out_lags, exp_q[0][EW-1:NP]);
            check("bp_found_hold", out_found, exp_q[0][NP-1:0]);
            @(posedge clk); #1;
            in_valid = i[0];
            in_data  = '1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        check("bp_idle_busy", busy, 0);
        send_frame(2, 0);
        wait_drain();

        // Back-to-back frames with in_valid held high.
        send_frame(1, 1);
        send_frame(3, 1);
        send_frame(4, 1);
        send_frame(2, 0);
        wait_drain();

        // Asynchronous reset during SCAN cycle 40.
        send_frame(4, 0);
        repeat (39) @(posedge clk);
        check("scan_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_lags", out_lags, 18'h3FFFF);
        check("arst_out_found", out_found, 0);
        void'(exp_q.pop_back());
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (130) @(negedge clk);
        check("arst_no_pulse", out_valid, 0);
        send_frame(3, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
